// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   Host-side SPI master for the SPI_Wrapper slave. It takes one command per
//   frame over a valid/ready handshake and serializes it as a start bit, three
//   command bits and eight data bits. For read-data frames it then waits
//   TURNAROUND cycles and captures eight MISO bits. MOSI/MISO run one bit per
//   CLK cycle, and there is no generated SCLK.
//
// Ports
//   CLK        system clock; all logic is on posedge
//   rst_n      synchronous active-low reset
//   cmd_valid  host command valid
//   cmd_ready  master can accept a command (IDLE only)
//   cmd_op     00 write-addr, 01 write-data, 10 read-addr, 11 read-data
//   cmd_data   address/data byte; sent as dummy zeros for op 11
//   rd_valid   one-cycle pulse, rd_data valid
//   rd_data    byte captured from MISO; held until the next completed read
//   busy       frame or inter-frame gap in progress
//   MOSI       serial data to slave
//   MISO       serial data from slave (sampled only in CAPT)
//   SS_n       slave select, active low
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | cmd_ready=1, waiting for a command
// S_START | 1 cycle, SS_n low, MOSI=0
// S_CMD   | 3 cycles, MOSI = op[1], op[1], op[0]
// S_DATA  | 8 cycles, byte LSB first (zeros for read-data)
// S_TURN  | TURNAROUND cycles before the first MISO sample (read-data)
// S_CAPT  | 8 cycles, MISO shifted in LSB first (read-data)
// S_GAP   | IDLE_GAP cycles with SS_n high
module spi_master_ctrl #(
  parameter int TURNAROUND = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS_n
);

  localparam int MAX_A = (TURNAROUND > 8) ? TURNAROUND : 8;
  localparam int MAX_B = (IDLE_GAP > MAX_A) ? IDLE_GAP : MAX_A;
  localparam int CNT_W = $clog2(MAX_B);

  localparam logic [CNT_W-1:0] CMD_LOAD  = CNT_W'(2);
  localparam logic [CNT_W-1:0] BYTE_LOAD = CNT_W'(7);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_CMD   = 3'd2,
    S_DATA  = 3'd3,
    S_TURN  = 3'd4,
    S_CAPT  = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [7:0]       tx_q;
  logic [7:0]       rx_q;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            tx_q      <= cmd_data;
            state     <= S_START;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            SS_n      <= 1'b0;
            MOSI      <= 1'b0;
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
          end
        end

        S_START: begin
          state <= S_CMD;
          cnt   <= CMD_LOAD;
          MOSI  <= op_q[1];
        end

        // The read/write select bit (op[1]) is sent twice, then op[0].
        S_CMD: begin
          if (cnt == '0) begin
            state <= S_DATA;
            cnt   <= BYTE_LOAD;
            MOSI  <= (op_q == 2'b11) ? 1'b0 : tx_q[0];
            tx_q  <= {1'b0, tx_q[7:1]};
          end else begin
            cnt  <= cnt - CNT_W'(1);
            MOSI <= (cnt == CNT_W'(1)) ? op_q[0] : op_q[1];
          end
        end

        S_DATA: begin
          if (cnt == '0) begin
            MOSI <= 1'b0;
            if (op_q == 2'b11) begin
              state <= S_TURN;
              cnt   <= TURN_LOAD;
            end else begin
              state <= S_GAP;
              cnt   <= GAP_LOAD;
              SS_n  <= 1'b1;
            end
          end else begin
            cnt  <= cnt - CNT_W'(1);
            MOSI <= (op_q == 2'b11) ? 1'b0 : tx_q[0];
            tx_q <= {1'b0, tx_q[7:1]};
          end
        end

        S_TURN: begin
          if (cnt == '0) begin
            state <= S_CAPT;
            cnt   <= BYTE_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        // First sample lands in bit 0 after eight right shifts.
        S_CAPT: begin
          rx_q <= {MISO, rx_q[7:1]};
          if (cnt == '0) begin
            rd_data  <= {MISO, rx_q[7:1]};
            rd_valid <= 1'b1;
            state    <= S_GAP;
            cnt      <= GAP_LOAD;
            SS_n     <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_GAP: begin
          if (cnt == '0) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          SS_n      <= 1'b1;
          MOSI      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
//   Scoreboard bench for spi_master_ctrl. The stimulus side holds an abstract
//   slave model (a 256-byte memory plus write/read address registers). For
//   each accepted command it pushes the expected frame: the MOSI bit pattern,
//   the SS_n-low length, and, for reads, the byte returned on MISO.
//   The monitor pops one entry per SS_n-low window. It drives MISO in the
//   capture window (random noise elsewhere) and checks the frame, the
//   rd_valid/rd_data response and the SS_n-high gap.
module tb_spi_master_ctrl #(
  parameter int TURNAROUND = 2,
  parameter int IDLE_GAP   = 1
);

  logic       clk_tb = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       MOSI;
  logic       MISO;
  logic       SS_n;

  always #5 clk_tb = ~clk_tb;

  spi_master_ctrl #(.TURNAROUND(TURNAROUND), .IDLE_GAP(IDLE_GAP)) dut (
    .CLK(clk_tb), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
  );

  typedef struct {
    logic [1:0]  op;
    logic [11:0] mosi;
    int          len;
    logic [7:0]  rd;
    bit          b2b;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] rd_addr = 8'h00;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- monitor ----------------
  bit         in_frame = 0;
  bit         have_prev = 0;
  int         j = 0;
  int         bit_err = 0;
  int         gap_cnt = 0;
  logic [7:0] last_rd = 8'h00;
  frame_t     cur;

  always @(negedge clk_tb) begin
    if (!rst_n) begin
      in_frame = 0;
      have_prev = 0;
      last_rd = 8'h00;
      MISO = 1'b0;
    end else begin
      if (cmd_ready && busy) chk("ready_while_busy", 1, 0);
      if (!in_frame && !SS_n) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          cur = '{op: 2'b00, mosi: 12'h000, len: 0, rd: 8'h00, b2b: 1'b0};
        end else begin
          cur = exp_q.pop_front();
        end
        if (have_prev) begin
          if (cur.b2b) chk("gap_b2b", gap_cnt, IDLE_GAP + 1);
          else chk("gap_min", (gap_cnt >= IDLE_GAP + 1) ? 1 : 0, 1);
        end
        in_frame = 1;
        j = 0;
        bit_err = 0;
      end
      if (in_frame && !SS_n) begin
        if (MOSI !== ((j < 12) ? cur.mosi[j] : 1'b0)) bit_err++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || rd_valid !== 1'b0) bit_err++;
        if (cur.op == 2'b11 && j >= 12 + TURNAROUND && j < 20 + TURNAROUND)
          MISO = cur.rd[j - 12 - TURNAROUND];
        else
          MISO = 1'($urandom);
        j++;
      end else if (in_frame && SS_n) begin
        chk("frame_len", j, cur.len);
        chk("frame_bits", bit_err, 0);
        chk("rd_valid_at_gap", rd_valid, (cur.op == 2'b11) ? 1 : 0);
        if (cur.op == 2'b11) last_rd = cur.rd;
        chk("rd_data", rd_data, last_rd);
        in_frame = 0;
        have_prev = 1;
        gap_cnt = 1;
        MISO = 1'($urandom);
      end else begin
        gap_cnt++;
        if (rd_valid) chk("stray_rd_valid", 1, 0);
        MISO = 1'($urandom);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] op, input logic [7:0] d, input bit b2b);
    frame_t e;
    bit ok = 0;
    e.op = op;
    e.mosi[0] = 1'b0;
    e.mosi[1] = op[1];
    e.mosi[2] = op[1];
    e.mosi[3] = op[0];
    for (int i = 0; i < 8; i++) e.mosi[4 + i] = (op == 2'b11) ? 1'b0 : d[i];
    e.len = (op == 2'b11) ? (1 + 3 + 8 + TURNAROUND + 8) : 12;
    e.rd  = (op == 2'b11) ? mem[rd_addr] : 8'h00;
    e.b2b = b2b;
    case (op)
      2'b00: wr_addr = d;
      2'b01: mem[wr_addr] = d;
      2'b10: rd_addr = d;
      default: ;
    endcase
    @(negedge clk_tb);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    for (int n = 0; n < 200; n++) begin
      if (cmd_ready) begin
        exp_q.push_back(e);
        @(posedge clk_tb);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_data = 8'($urandom);
        ok = 1;
        break;
      end
      @(negedge clk_tb);
    end
    if (!ok) begin
      cmd_valid = 1'b0;
      chk("accept_timeout", 0, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_data = 8'h00;
    MISO = 1'b0;

    repeat (3) @(negedge clk_tb);
    chk("rst_SS_n", SS_n, 1);
    chk("rst_MOSI", MOSI, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_busy", busy, 0);
    #1 rst_n = 1'b1;
    @(negedge clk_tb);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);

    // Read-data aborted by reset during the 5th capture cycle.
    send(2'b11, 8'h00, 1'b0);
    repeat (12 + TURNAROUND + 5) @(negedge clk_tb);
    #1 rst_n = 1'b0;
    @(posedge clk_tb);
    @(negedge clk_tb);
    chk("abort_SS_n", SS_n, 1);
    chk("abort_MOSI", MOSI, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_rd_data", rd_data, 8'h00);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk_tb);
    chk("abort_no_rd_valid", rd_valid, 0);

    // Write-addr 0x5A, write 0xC3, read it back (MISO bits 1,1,0,0,0,0,1,1).
    send(2'b00, 8'h5A, 1'b0);
    send(2'b01, 8'hC3, 1'b1);
    send(2'b10, 8'h5A, 1'b1);
    send(2'b11, 8'h00, 1'b1);
    // Write/read-back at 0x21.
    send(2'b00, 8'h21, 1'b1);
    send(2'b01, 8'hA5, 1'b1);
    send(2'b10, 8'h21, 1'b1);
    send(2'b11, 8'hFF, 1'b1);

    // Randomized commands, either back-to-back or after an idle stretch.
    for (int k = 0; k < 40; k++) begin
      bit b2b;
      b2b = 1'($urandom);
      if (!b2b) repeat (40 + $urandom_range(0, 10)) @(negedge clk_tb);
      send(2'($urandom), 8'($urandom), b2b);
    end

    for (int n = 0; n < 300; n++) begin
      if (exp_q.size() == 0 && !in_frame) break;
      @(negedge clk_tb);
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_frame", in_frame, 0);
    repeat (IDLE_GAP + 3) @(negedge clk_tb);
    chk("final_idle_ready", cmd_ready, 1);
    chk("final_rd_hold", rd_data, last_rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
